// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_pkg
// Description : Shared types and encodings for the accumulator controller:
//               FSM state enum, operation codes and requester source codes.
// Revision    : 1.0 - initial release
// ============================================================================
package accum_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  // Operation encoding (matches the software sw_op bit)
  localparam logic OP_ACC = 1'b0;
  localparam logic OP_CLR = 1'b1;

  // Requester encoding, also used for the round-robin last_grant bit
  localparam logic SRC_HW = 1'b0;
  localparam logic SRC_SW = 1'b1;

endpackage : accum_pkg
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Raw asynchronous key -> 2-FF synchronizer -> debounce counter
//               -> one-cycle pulse on each accepted rising level.
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_i,
  output logic pulse_o
);

  localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;

  // Two-stage synchronizer for the asynchronous key input
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  // Count cycles the synchronized level differs from the accepted level; any
  // return to the accepted level reloads the counter, so bounces never pass.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = level_d & ~level_q;
  end

  // Debounce counter, accepted level and registered rising-edge pulse
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule : key_debounce
`default_nettype wire

// File: rtl/accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : accum_ctrl
// Description : Shares an accumulator between debounced pushbuttons and a
//               software req/ack handshake; arbitrates and applies exactly
//               one accumulate or clear per grant.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_ctrl
  import accum_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             acc_key,
  input  logic             clr_key,
  input  logic [WIDTH-1:0] sw,
  input  logic             sw_req,
  input  logic             sw_op,
  input  logic [WIDTH-1:0] sw_data,
  output logic             sw_ack,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             busy
);

  logic acc_pulse, clr_pulse;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_acc_db (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .key_i   (acc_key),
    .pulse_o (acc_pulse)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .key_i   (clr_key),
    .pulse_o (clr_pulse)
  );

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             hw_acc_pend_q, hw_acc_pend_d;
  logic             hw_clr_pend_q, hw_clr_pend_d;
  logic             last_grant_q, last_grant_d;
  logic             op_q, op_d;
  logic             src_q, src_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic             sw_acc_req, sw_clr_req, hw_wins;
  logic [WIDTH:0]   add_res;

  assign sw_acc_req = sw_req & (sw_op == OP_ACC);
  assign sw_clr_req = sw_req & (sw_op == OP_CLR);
  // Hardware takes an accumulate slot when alone, or on a tie when software
  // won the previous contested tie.
  assign hw_wins    = hw_acc_pend_q & (~sw_acc_req | (last_grant_q == SRC_SW));
  assign add_res    = {1'b0, sum_q} + {1'b0, opnd_q};

  // Arbitration, execution and handshake sequencing
  always_comb begin
    state_d       = state_q;
    sum_d         = sum_q;
    ovf_d         = ovf_q;
    hw_acc_pend_d = hw_acc_pend_q;
    hw_clr_pend_d = hw_clr_pend_q;
    last_grant_d  = last_grant_q;
    op_d          = op_q;
    src_d         = src_q;
    opnd_d        = opnd_q;

    case (state_q)
      ST_IDLE: begin
        if (hw_clr_pend_q) begin
          op_d    = OP_CLR;
          src_d   = SRC_HW;
          opnd_d  = '0;
          state_d = ST_EXEC;
        end else if (sw_clr_req) begin
          op_d    = OP_CLR;
          src_d   = SRC_SW;
          opnd_d  = '0;
          state_d = ST_EXEC;
        end else if (hw_acc_pend_q | sw_acc_req) begin
          op_d    = OP_ACC;
          state_d = ST_EXEC;
          if (hw_wins) begin
            src_d  = SRC_HW;
            opnd_d = sw;
          end else begin
            src_d  = SRC_SW;
            opnd_d = sw_data;
          end
          // Only a contested tie moves the round-robin pointer
          if (hw_acc_pend_q & sw_acc_req) begin
            last_grant_d = hw_wins ? SRC_HW : SRC_SW;
          end
        end
      end

      ST_EXEC: begin
        if (op_q == OP_CLR) begin
          sum_d = '0;
          ovf_d = 1'b0;
        end else begin
          sum_d = add_res[WIDTH-1:0];
          ovf_d = ovf_q | add_res[WIDTH];
        end
        if (src_q == SRC_HW) begin
          if (op_q == OP_CLR) begin
            hw_clr_pend_d = 1'b0;
          end else begin
            hw_acc_pend_d = 1'b0;
          end
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end

      ST_ACK: begin
        if (!sw_req) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // New key edges always land, even on the cycle a pending op retires
    hw_acc_pend_d = hw_acc_pend_d | acc_pulse;
    hw_clr_pend_d = hw_clr_pend_d | clr_pulse;
  end

  // Controller state, accumulator and latched grant
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      sum_q         <= '0;
      ovf_q         <= 1'b0;
      hw_acc_pend_q <= 1'b0;
      hw_clr_pend_q <= 1'b0;
      last_grant_q  <= SRC_SW;
      op_q          <= OP_ACC;
      src_q         <= SRC_HW;
      opnd_q        <= '0;
    end else begin
      state_q       <= state_d;
      sum_q         <= sum_d;
      ovf_q         <= ovf_d;
      hw_acc_pend_q <= hw_acc_pend_d;
      hw_clr_pend_q <= hw_clr_pend_d;
      last_grant_q  <= last_grant_d;
      op_q          <= op_d;
      src_q         <= src_d;
      opnd_q        <= opnd_d;
    end
  end

  assign sw_ack   = (state_q == ST_ACK);
  assign busy     = (state_q != ST_IDLE);
  assign sum      = sum_q;
  assign overflow = ovf_q;

endmodule : accum_ctrl
`default_nettype wire

// File: tb/tb_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_ctrl
// Description : Self-checking bench for accum_ctrl with a behavioural model
//               of the accumulator and arbitration order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       acc_key, clr_key;
  logic [7:0] sw;
  logic       sw_req, sw_op;
  logic [7:0] sw_data;
  logic       sw_ack;
  logic [7:0] sum;
  logic       overflow;
  logic       busy;

  accum_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .acc_key  (acc_key),
    .clr_key  (clr_key),
    .sw       (sw),
    .sw_req   (sw_req),
    .sw_op    (sw_op),
    .sw_data  (sw_data),
    .sw_ack   (sw_ack),
    .sum      (sum),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integer arithmetic plus a tie-order flag
  int exp_sum;
  bit exp_ovf;
  bit rr_hw_next;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_acc(input int v);
    int t;
    t = exp_sum + v;
    if (t > 255) exp_ovf = 1'b1;
    exp_sum = t % 256;
  endfunction

  function automatic void model_clr();
    exp_sum = 0;
    exp_ovf = 1'b0;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && busy; i++) tick();
    chk({tag, "_idle_to"}, busy, 0);
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 40 && !sw_ack; i++) tick();
    chk({tag, "_ack_to"}, sw_ack, 1);
  endtask

  task automatic check_acc(input string tag);
    chk({tag, "_sum"}, sum, exp_sum);
    chk({tag, "_ovf"}, overflow, exp_ovf);
  endtask

  // Full software transaction; result checked on the acknowledge cycle
  task automatic sw_txn(input bit op, input int data, input string tag);
    sw_op   = op;
    sw_data = data[7:0];
    sw_req  = 1'b1;
    wait_ack(tag);
    if (op) model_clr(); else model_acc(data);
    check_acc(tag);
    sw_req = 1'b0;
    tick();
    chk({tag, "_ackdrop"}, sw_ack, 0);
    wait_idle(tag);
  endtask

  // Clean press and release of one key, long enough to complete the op
  task automatic press(input bit clr);
    if (clr) clr_key = 1'b1; else acc_key = 1'b1;
    repeat (12) tick();
    clr_key = 1'b0;
    acc_key = 1'b0;
    repeat (12) tick();
  endtask

  // Leave software parked in ACK (zero accumulate) so hw events queue up
  task automatic hold_sw_in_ack(input string tag);
    sw_op   = 1'b0;
    sw_data = 8'h00;
    sw_req  = 1'b1;
    wait_ack(tag);
  endtask

  // hw acc and sw acc both pending in the same IDLE cycle
  task automatic rr_tie(input int hw_v, input int sw_v, input string tag);
    sw = hw_v[7:0];
    hold_sw_in_ack(tag);
    acc_key = 1'b1;
    repeat (12) tick();
    sw_req = 1'b0;
    tick();
    sw_op   = 1'b0;
    sw_data = sw_v[7:0];
    sw_req  = 1'b1;
    tick();
    tick();
    if (rr_hw_next) begin
      model_acc(hw_v);
      check_acc({tag, "_first_hw"});
      chk({tag, "_noack"}, sw_ack, 0);
      wait_ack(tag);
      model_acc(sw_v);
      check_acc({tag, "_second_sw"});
      sw_req = 1'b0;
      tick();
      wait_idle(tag);
    end else begin
      model_acc(sw_v);
      check_acc({tag, "_first_sw"});
      chk({tag, "_ack"}, sw_ack, 1);
      sw_req = 1'b0;
      tick();
      tick();
      tick();
      wait_idle(tag);
      model_acc(hw_v);
      check_acc({tag, "_second_hw"});
    end
    rr_hw_next = ~rr_hw_next;
    acc_key = 1'b0;
    repeat (12) tick();
    check_acc({tag, "_after_release"});
  endtask

  initial begin
    Reset   = 1'b1;
    acc_key = 1'b0;
    clr_key = 1'b0;
    sw      = 8'h00;
    sw_req  = 1'b0;
    sw_op   = 1'b0;
    sw_data = 8'h00;
    model_clr();
    rr_hw_next = 1'b1;
    repeat (3) tick();
    chk("rst_sum", sum, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", sw_ack, 0);
    Reset = 1'b0;
    tick();

    // Reset arriving while an accumulate is in EXEC
    sw_txn(1'b0, 8'h23, "pre_rst");
    sw_op   = 1'b0;
    sw_data = 8'h01;
    sw_req  = 1'b1;
    tick();
    chk("mid_exec_busy", busy, 1);
    Reset = 1'b1;
    #1;
    chk("async_rst_sum", sum, 0);
    chk("async_rst_ovf", overflow, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ack", sw_ack, 0);
    sw_req = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    model_clr();
    rr_hw_next = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_sum", sum, 0);

    // Three clean hardware accumulates of the switch value
    sw = 8'h05;
    for (int i = 0; i < 3; i++) begin
      press(1'b0);
      model_acc(5);
      check_acc("hw_acc");
    end

    // Bouncing key: short glitches never qualify, final stable high does
    for (int i = 0; i < 10; i++) begin
      acc_key = ~acc_key;
      repeat (2) tick();
    end
    press(1'b0);
    model_acc(5);
    check_acc("bounce");

    // Wrap with overflow, exact acknowledge timing, sticky flag, clear
    sw_txn(1'b1, 0, "clr0");
    sw_txn(1'b0, 8'hFE, "set_fe");
    sw_op   = 1'b0;
    sw_data = 8'h03;
    sw_req  = 1'b1;
    tick();
    chk("wrap_n1_ack", sw_ack, 0);
    chk("wrap_n1_busy", busy, 1);
    tick();
    model_acc(3);
    chk("wrap_n2_ack", sw_ack, 1);
    check_acc("wrap");
    tick();
    tick();
    chk("wrap_hold_ack", sw_ack, 1);
    sw_req = 1'b0;
    tick();
    chk("wrap_drop_ack", sw_ack, 0);
    chk("wrap_drop_busy", busy, 0);
    sw_txn(1'b0, 8'h02, "sticky");
    sw_txn(1'b1, 0, "sw_clr");

    // Pending hw clear beats a simultaneous sw accumulate
    sw_txn(1'b0, 8'h40, "set_40");
    hold_sw_in_ack("prio_hold");
    clr_key = 1'b1;
    repeat (12) tick();
    clr_key = 1'b0;
    repeat (12) tick();
    chk("prio_parked", sw_ack, 1);
    sw_req = 1'b0;
    tick();
    sw_op   = 1'b0;
    sw_data = 8'h10;
    sw_req  = 1'b1;
    tick();
    tick();
    model_clr();
    check_acc("prio_clr_first");
    wait_ack("prio");
    model_acc(8'h10);
    check_acc("prio_acc_second");
    sw_req = 1'b0;
    tick();
    wait_idle("prio");

    // Two accumulate ties: order alternates
    rr_tie(8'h01, 8'h10, "rr1");
    rr_tie(8'h01, 8'h10, "rr2");

    // Randomized single operations
    for (int i = 0; i < 16; i++) begin
      int sel;
      int v;
      sel = $urandom_range(0, 7);
      v   = $urandom_range(0, 255);
      if (sel <= 2) begin
        sw = v[7:0];
        press(1'b0);
        model_acc(v);
        check_acc("rnd_hw_acc");
      end else if (sel == 3) begin
        press(1'b1);
        model_clr();
        check_acc("rnd_hw_clr");
      end else if (sel <= 6) begin
        sw_txn(1'b0, v, "rnd_sw_acc");
      end else begin
        sw_txn(1'b1, 0, "rnd_sw_clr");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_accum_ctrl
`default_nettype wire

// File: doc/accum_ctrl.md
# accum_ctrl

Fabric-side controller that owns the 8-bit accumulator behind the switch/LED path on the DE2 board and shares it between two requesters: the physical pushbuttons (accumulate, clear) and the Nios II software through a PIO request/acknowledge pair. It synchronizes and debounces the raw keys, arbitrates pending operations, and applies exactly one accumulate or clear per grant. It sits in the top level beside the SoC instance: keys and SW in, running sum out to LEDG.

## Interface
- WIDTH, 8: accumulator and operand width.
- DEBOUNCE_CYCLES, 500000: cycles a synchronized key level must hold before it is accepted (10 ms at 50 MHz).
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  asynchronous, active-high reset.
- acc_key  in  1  raw accumulate button, active-high (already inverted from KEY), asynchronous.
- clr_key  in  1  raw clear button, active-high, asynchronous.
- sw  in  WIDTH  switch operand for hardware accumulate.
- sw_req  in  1  software request, 4-phase level handshake.
- sw_op  in  1  software op: 0 = accumulate sw_data, 1 = clear.
- sw_data  in  WIDTH  software operand.
- sw_ack  out  1  software acknowledge.
- sum  out  WIDTH  accumulator value (drives LEDG).
- overflow  out  1  sticky carry-out flag.
- busy  out  1  high whenever FSM is not IDLE.

## Operation
- Each key: 2-FF synchronizer -> debounce counter (reload on any level change, accept level after DEBOUNCE_CYCLES stable) -> rising-edge detect giving a one-cycle pulse.
- Pulse sets hw_acc_pend / hw_clr_pend. A pulse while the flag is already set merges (one op). Flags clear on the edge their op executes.
- FSM states: IDLE, EXEC, ACK.
- IDLE: grant by priority: (1) hw clear, (2) sw clear, (3) accumulates, round-robin between hw and sw via last_grant bit (reset value: sw, so hw wins first tie). Grant latched with operand (sw or sw_data) -> EXEC. No request -> stay.
- EXEC: one cycle; apply op. Accumulate: sum <= sum + operand mod 2^WIDTH; overflow <= overflow | carry. Clear: sum <= 0, overflow <= 0. Next: ACK if software was granted, else IDLE.
- ACK: sw_ack = 1; stay while sw_req = 1; leave to IDLE on sw_req = 0, sw_ack falls on that edge.
- sw_req sampled only in IDLE; dropping it before grant cancels with no effect. A new sw_req may be granted only after passing through IDLE with sw_req low (no re-execution of a held request).
- Hardware edges during EXEC/ACK stay pending, never lost.

## Timing
- Reset (any time, async): sum = 0, overflow = 0, sw_ack = 0, busy = 0, state IDLE, pending flags 0, synchronizers/debounced levels 0, counters 0, last_grant = sw. Operation in flight is discarded.
- Key press to pending flag: 2 sync + DEBOUNCE_CYCLES + 1 edge-detect cycle.
- Grant in IDLE at cycle N -> EXEC at N+1 -> sum/overflow updated visible at N+2.
- Software: sw_req high seen in IDLE at N -> sw_ack high at N+2 (same cycle new sum visible) -> sw_ack low one cycle after sw_req low observed.
- busy high from N+1 until return to IDLE.
- Wrap: 0xFF + 0x01 -> 0x00, overflow = 1; stays 1 through further accumulates until clear.

## Structure
- Package accum_pkg: state enum (IDLE, EXEC, ACK), op encoding constants OP_ACC = 0, OP_CLR = 1, source encoding SRC_HW/SRC_SW.
- Sub-module key_debounce (sync, debounce counter, edge pulse; parameter DEBOUNCE_CYCLES), instantiated twice. Counter width $clog2(DEBOUNCE_CYCLES+1).

## Test plan (bench uses DEBOUNCE_CYCLES = 4)
- Reset mid-EXEC with sum = 0x23 -> all outputs 0 immediately, FSM IDLE after release.
- sw = 0x05, press acc_key cleanly three times -> sum 0x05, 0x0A, 0x0F; overflow 0.
- acc_key bouncing (toggles every 2 cycles for 20 cycles, then stable high) -> exactly one accumulate.
- sum = 0xFE, sw request acc sw_data = 0x03 -> sum 0x01, overflow 1, sw_ack at N+2, drops after sw_req low; then sw clear -> sum 0, overflow 0.
- Same-cycle hw clear pending + sw acc 0x10 with sum 0x40 -> clear first (0x00), then acc -> 0x10.
- hw acc and sw acc pending simultaneously twice -> order hw, sw, then next tie sw, hw (round-robin).
